// File: rtl/sr_cmd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sr_cmd_seq
//  Purpose  : Queues set/reset commands and drives them one at a time onto
//             the s/r inputs of a downstream SR flip-flop. Each command is a
//             PULSE_W-cycle pulse, then a one-cycle quiet gap, then a wait of
//             up to TIMEOUT cycles for q_fb to confirm the requested level.
//             A confirmed command pulses done; an unconfirmed one sets the
//             sticky err flag. s and r are never high together.
//  Options  : SR_CMD_SKIP_EN - when defined, a popped command whose level
//             already matches q_fb is acknowledged with done on the next
//             cycle and never drives s or r.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_seq #(
  parameter int PULSE_W = 2,   // cycles s or r is held per command (1..15)
  parameter int DEPTH   = 4,   // command FIFO entries (power of 2, 2..16)
  parameter int TIMEOUT = 8    // confirmation wait limit in cycles (1..255)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err,
  input  logic err_clr
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // pointer width
  localparam int CW = AW + 1;                            // occupancy width

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Last value of each phase counter; the phase ends on the edge where the
  // counter already holds this value.
  localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  // Command FIFO (one bit per entry: 1 = set, 0 = reset)
  logic [DEPTH-1:0] fifo_mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             push;
  logic             pop;
  logic             head_op;
  logic             skip_hit;

  // Sequencer state and phase counters
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       drive_cnt;
  logic [3:0]       drive_cnt_nxt;
  logic [7:0]       to_cnt;
  logic [7:0]       to_cnt_nxt;

  // Command being executed
  logic             op_q;

  // Next values of the registered outputs
  logic             s_nxt;
  logic             r_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic             timeout_hit;
  logic             confirm_hit;

  // --------------------------------------------------------------------------
  // FIFO handshake and status
  // --------------------------------------------------------------------------
  // Accept whenever there is room; a push while full is simply not taken.
  assign req_ready = (count < DEPTH_C);
  assign push      = req_valid & req_ready;

  // The sequencer only takes a new command while it is idle.
  assign pop       = (state == ST_IDLE) && (count != '0);
  assign head_op   = fifo_mem[rd_ptr];

  // Busy covers both queued work and a command still in flight.
  assign busy      = (state != ST_IDLE) || (count != '0);

`ifdef SR_CMD_SKIP_EN
  // The flip-flop already holds the requested level: nothing to drive.
  assign skip_hit  = (head_op == q_fb);
`else
  // Every command is driven and confirmed, whatever q_fb shows.
  assign skip_hit  = 1'b0;
`endif

  // Confirmation and timeout conditions while waiting in CHECK.
  assign confirm_hit = (q_fb == op_q);

  // --------------------------------------------------------------------------
  // FIFO storage: payload needs no reset, occupancy tracking does
  // --------------------------------------------------------------------------
  // Write the incoming command bit into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= req_op;
    end
  end

  // Advance pointers and occupancy; push and pop together leave count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and phase-counter logic.
  always_comb begin
    state_nxt     = state;
    drive_cnt_nxt = drive_cnt;
    to_cnt_nxt    = to_cnt;
    case (state)
      ST_IDLE: begin
        if (pop && !skip_hit) begin
          state_nxt     = ST_DRIVE;
          drive_cnt_nxt = '0;
        end
      end
      ST_DRIVE: begin
        if (drive_cnt == PW_LAST) begin
          state_nxt = ST_GAP;
        end else begin
          drive_cnt_nxt = drive_cnt + 4'd1;
        end
      end
      ST_GAP: begin
        state_nxt  = ST_CHECK;
        to_cnt_nxt = '0;
      end
      ST_CHECK: begin
        if (confirm_hit || (to_cnt == TO_LAST)) begin
          state_nxt = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    s_nxt       = 1'b0;
    r_nxt       = 1'b0;
    done_nxt    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          if (skip_hit) begin
            done_nxt = 1'b1;
          end else begin
            // s and r are always complementary copies of one bit, so the
            // forbidden s=r=1 combination cannot be produced.
            s_nxt = head_op;
            r_nxt = ~head_op;
          end
        end
      end
      ST_DRIVE: begin
        if (drive_cnt != PW_LAST) begin
          s_nxt = op_q;
          r_nxt = ~op_q;
        end
      end
      ST_CHECK: begin
        if (confirm_hit) begin
          done_nxt = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
        end
      end
      default: begin
        s_nxt = 1'b0;
        r_nxt = 1'b0;
      end
    endcase

    // A timeout on the same edge as a clear request keeps the flag set.
    if (timeout_hit) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end else begin
      err_nxt = err;
    end
  end

  // Output, latched-command and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      op_q      <= 1'b0;
      drive_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      s         <= s_nxt;
      r         <= r_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      drive_cnt <= drive_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      if (pop) begin
        op_q <= head_op;
      end
    end
  end

endmodule
`default_nettype wire
